// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register peripheral.
package spi_reg_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } spi_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one async input with registered rise/fall pulses.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 slave register file driving the PWM/output-enable stage.
// Optional register readback on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned FRAME_BITS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic              cipo,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              wr_strobe
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic copi_level, copi_rise_unused, copi_fall_unused;
    logic ncs_rise, ncs_fall, ncs_level_unused;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(copi),
        .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(ncs),
        .level(ncs_level_unused), .rise(ncs_rise), .fall(ncs_fall)
    );

    spi_state_t            state_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] shift_nxt;
    logic                  ovf_q;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [ADDR_W-1:0]     addr;
    logic                  commit_ok;

    assign shift_nxt = {shift_q[FRAME_BITS-2:0], copi_level};
    assign addr      = shift_q[DATA_W +: ADDR_W];
    // A rise past the last bit marks the frame as too long so it can never commit.
    assign commit_ok = (bit_cnt_q == CNT_W'(FRAME_BITS)) && !ovf_q &&
                       shift_q[FRAME_BITS-1] && (32'(addr) < NUM_REGS);

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rd_data;
    logic              cipo_q;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (shift_nxt[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs_q[i];
        end
    end

    assign cipo = cipo_q;
`else
    logic unused_sclk_fall;
    assign unused_sclk_fall = sclk_fall;
    assign cipo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ovf_q     <= 1'b0;
            wr_strobe <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef SPI_READBACK_EN
            tx_q      <= '0;
            cipo_q    <= 1'b0;
`endif
        end else begin
            wr_strobe <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ncs_fall) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                        ovf_q     <= 1'b0;
                    end
                end
                SHIFT: begin
                    // ncs rise takes priority over a coincident sclk edge.
                    if (ncs_rise) begin
                        state_q <= commit_ok ? COMMIT : IDLE;
`ifdef SPI_READBACK_EN
                        cipo_q  <= 1'b0;
`endif
                    end else begin
                        if (sclk_rise) begin
                            if (bit_cnt_q < CNT_W'(FRAME_BITS)) begin
                                shift_q   <= shift_nxt;
                                bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef SPI_READBACK_EN
                                if (bit_cnt_q == CNT_W'(FRAME_BITS - DATA_W - 1)) begin
                                    tx_q <= shift_nxt[DATA_W-1] ? '0 : rd_data;
                                end
`endif
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end
`ifdef SPI_READBACK_EN
                        if (sclk_fall) begin
                            if (bit_cnt_q >= CNT_W'(FRAME_BITS - DATA_W) &&
                                bit_cnt_q < CNT_W'(FRAME_BITS)) begin
                                cipo_q <= tx_q[DATA_W-1];
                                tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                            end else begin
                                cipo_q <= 1'b0;
                            end
                        end
`endif
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr == ADDR_W'(i)) regs_q[i] <= shift_q[DATA_W-1:0];
                    end
                    wr_strobe <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = regs_q[int'(ADDR_EN_OUT_LO)];
    assign en_reg_out_15_8 = regs_q[int'(ADDR_EN_OUT_HI)];
    assign en_reg_pwm_7_0  = regs_q[int'(ADDR_EN_PWM_LO)];
    assign en_reg_pwm_15_8 = regs_q[int'(ADDR_EN_PWM_HI)];
    assign pwm_duty_cycle  = regs_q[int'(ADDR_DUTY)];

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral with a frame-level register model.
module tb_spi_reg_peripheral;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic copi = 1'b0;
    logic ncs = 1'b1;
    logic cipo, wr_strobe;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    spi_reg_peripheral dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_regs [128];
    logic       exp_strobe = 1'b0;
    bit         chk_en = 1'b0;
    bit         cipo_free = 1'b0;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         dut_strobes = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("reg0", en_reg_out_7_0, exp_regs[0]);
            check("reg1", en_reg_out_15_8, exp_regs[1]);
            check("reg2", en_reg_pwm_7_0, exp_regs[2]);
            check("reg3", en_reg_pwm_15_8, exp_regs[3]);
            check("reg4", pwm_duty_cycle, exp_regs[4]);
            check("wr_strobe", {7'd0, wr_strobe}, {7'd0, exp_strobe});
            if (!cipo_free) check("cipo_idle", {7'd0, cipo}, 8'd0);
            if (wr_strobe === 1'b1) dut_strobes++;
        end
    end

    // Sends the low nbits of frame MSB-first; the model commits only well-formed writes.
    task automatic spi_frame(input logic [31:0] frame, input int nbits);
        logic [6:0] addr;
        logic [7:0] rd;
        bit         commit;
        bit         is_rd;
        addr   = frame[14:8];
        commit = (nbits == 16) && frame[15] && (addr < 7'd5);
        is_rd  = (nbits == 16) && !frame[15];
        rd     = (addr < 7'd5) ? exp_regs[addr] : 8'h00;
`ifdef SPI_READBACK_EN
        if (is_rd) cipo_free = 1'b1;
`endif
        ncs = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = frame[i];
            repeat (HALF) @(posedge clk);
            #1;
`ifdef SPI_READBACK_EN
            if (is_rd && i < 8) check("rd_bit", {7'd0, cipo}, {7'd0, rd[i]});
`endif
            sclk = 1'b1;
            repeat (HALF) @(posedge clk);
            #1;
            sclk = 1'b0;
        end
        repeat (HALF) @(posedge clk);
        #1;
        ncs  = 1'b1;
        copi = 1'b0;
        repeat (5) @(posedge clk);
        if (commit) begin
            exp_regs[addr] = frame[7:0];
            exp_strobe     = 1'b1;
        end
        @(posedge clk);
        exp_strobe = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        cipo_free = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) exp_regs[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_reg0", en_reg_out_7_0, 8'h00);
        check("rst_reg4", pwm_duty_cycle, 8'h00);
        check("rst_strobe", {7'd0, wr_strobe}, 8'h00);
        check("rst_cipo", {7'd0, cipo}, 8'h00);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        spi_frame(32'h80F0, 16);
        check("t1_reg0", en_reg_out_7_0, 8'hF0);
        check("t1_strobes", 8'(dut_strobes), 8'd1);

        spi_frame(32'h8480, 16);
        spi_frame(32'h8201, 16);
        check("t2_duty", pwm_duty_cycle, 8'h80);
        check("t2_pwm_lo", en_reg_pwm_7_0, 8'h01);
        check("t2_out_hi", en_reg_out_15_8, 8'h00);

        spi_frame(32'hB0AA, 16);
        check("t3_strobes", 8'(dut_strobes), 8'd3);

        spi_frame(32'h813C, 16);
        spi_frame(32'h0205, 10);
        spi_frame(32'h20557, 18);
        check("t4_reg1", en_reg_out_15_8, 8'h3C);
        check("t4_strobes", 8'(dut_strobes), 8'd4);

        spi_frame(32'h80FF, 16);
        check("t5_pre_reg0", en_reg_out_7_0, 8'hFF);
        ncs = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        for (int i = 15; i >= 11; i--) begin
            copi = 1'(32'h8122 >> i);
            repeat (HALF) @(posedge clk);
            #1;
            sclk = 1'b1;
            repeat (HALF) @(posedge clk);
            #1;
            sclk = 1'b0;
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        for (int i = 0; i < 128; i++) exp_regs[i] = 8'h00;
        #1;
        check("t5_async_reg0", en_reg_out_7_0, 8'h00);
        check("t5_async_reg1", en_reg_out_15_8, 8'h00);
        check("t5_async_cipo", {7'd0, cipo}, 8'h00);
        ncs  = 1'b1;
        copi = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        spi_frame(32'h825A, 16);
        check("t5_pwm_lo", en_reg_pwm_7_0, 8'h5A);
        check("t5_reg0", en_reg_out_7_0, 8'h00);

        spi_frame(32'h83A5, 16);
        spi_frame(32'h0300, 16);
        spi_frame(32'h4000, 16);
        check("t6_pwm_hi", en_reg_pwm_15_8, 8'hA5);
        check("t6_strobes", 8'(dut_strobes), 8'd7);

        repeat (4) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
